// File: rtl/sseg_scan_reader_if.sv
// Observation-side bundle for the 7-segment scan reader: raw display lines in,
// recovered digits and status out.
interface sseg_scan_reader_if;
    logic [6:0]  SSeg;
    logic [3:0]  An;
    logic        ClrErr;
    logic [15:0] Digits;
    logic [3:0]  Valid;
    logic        Update;
    logic        BadSeg;

    modport master (
        output SSeg, An, ClrErr,
        input  Digits, Valid, Update, BadSeg
    );

    modport slave (
        input  SSeg, An, ClrErr,
        output Digits, Valid, Update, BadSeg
    );
endinterface

// File: rtl/sseg_scan_reader.sv
// Reads back a multiplexed common-anode 7-segment bus, debounces each digit
// and decodes the segment pattern to BCD with per-digit validity.
module sseg_scan_reader #(
    parameter int STABLE_CNT = 4
) (
    input  logic clk,
    input  logic rst_n,
    sseg_scan_reader_if.slave bus
);
    localparam logic [3:0] STABLE = 4'(STABLE_CNT);

    typedef enum logic [1:0] {DEC_DIGIT, DEC_BLANK, DEC_BAD} dec_kind_t;

    logic [6:0]      seg_s1, seg_sync;
    logic [3:0]      an_s1, an_sync;
    logic [1:0]      last_k;
    logic [6:0]      last_pat;
    logic [3:0]      run_cnt, cnt_nxt;
    logic [3:0][3:0] digit_q;
    logic [3:0]      valid_q;
    logic            update_q, bad_q;

    logic [3:0]      act;
    logic            legal, same, commit;
    logic [1:0]      cur_k;
    logic [3:0]      dec_val;
    dec_kind_t       dec_kind;

    // Two-flop synchronizers; reset values look like a blank, deselected bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_s1   <= 7'h7F;
            seg_sync <= 7'h7F;
            an_s1    <= 4'hF;
            an_sync  <= 4'hF;
        end else begin
            seg_s1   <= bus.SSeg;
            seg_sync <= seg_s1;
            an_s1    <= bus.An;
            an_sync  <= an_s1;
        end
    end

    always_comb begin
        act   = ~an_sync;
        legal = (act != 4'h0) && ((act & (act - 4'h1)) == 4'h0);
        cur_k = 2'd0;
        case (act)
            4'b0010: cur_k = 2'd1;
            4'b0100: cur_k = 2'd2;
            4'b1000: cur_k = 2'd3;
            default: cur_k = 2'd0;
        endcase
    end

    always_comb begin
        dec_val  = 4'hE;
        dec_kind = DEC_DIGIT;
        case (seg_sync)
            7'h40: dec_val = 4'd0;
            7'h79: dec_val = 4'd1;
            7'h24: dec_val = 4'd2;
            7'h30: dec_val = 4'd3;
            7'h19: dec_val = 4'd4;
            7'h12: dec_val = 4'd5;
            7'h02: dec_val = 4'd6;
            7'h78: dec_val = 4'd7;
            7'h00: dec_val = 4'd8;
            7'h10: dec_val = 4'd9;
            7'h7F: begin dec_val = 4'hF; dec_kind = DEC_BLANK; end
            default: begin dec_val = 4'hE; dec_kind = DEC_BAD; end
        endcase
    end

    // Commit only on the edge the run first reaches STABLE; a saturated run
    // stays quiet until a different or interrupted sample starts a new one.
    always_comb begin
        same    = legal && (cur_k == last_k) && (seg_sync == last_pat);
        cnt_nxt = run_cnt;
        if (!legal)
            cnt_nxt = 4'd0;
        else if (same)
            cnt_nxt = (run_cnt >= STABLE) ? run_cnt : run_cnt + 4'd1;
        else
            cnt_nxt = 4'd1;
        commit = legal && (cnt_nxt == STABLE) && !(same && run_cnt == STABLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_k   <= 2'd0;
            last_pat <= 7'h7F;
            run_cnt  <= 4'd0;
        end else begin
            run_cnt <= cnt_nxt;
            if (legal && !same) begin
                last_k   <= cur_k;
                last_pat <= seg_sync;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_q  <= '1;
            valid_q  <= '0;
            update_q <= 1'b0;
            bad_q    <= 1'b0;
        end else begin
            update_q <= commit;
            for (int i = 0; i < 4; i++) begin
                if (commit && cur_k == 2'(i)) begin
                    digit_q[i] <= dec_val;
                    valid_q[i] <= (dec_kind == DEC_DIGIT);
                end
            end
            // Set beats clear on the same edge.
            if (commit && dec_kind == DEC_BAD)
                bad_q <= 1'b1;
            else if (bus.ClrErr)
                bad_q <= 1'b0;
        end
    end

    assign bus.Digits = digit_q;
    assign bus.Valid  = valid_q;
    assign bus.Update = update_q;
    assign bus.BadSeg = bad_q;
endmodule

// File: tb/tb_sseg_scan_reader.sv
// Table-driven bench for sseg_scan_reader with a commit scoreboard popped on
// every Update pulse.
module tb_sseg_scan_reader;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    sseg_scan_reader_if bus();

    sseg_scan_reader #(.STABLE_CNT(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  an;
        logic [6:0]  seg;
        logic        clr;
        int          cycles;
        logic        commit;
        int          k;
        logic [3:0]  dig;
        logic        vld;
        logic [15:0] exp_digits;
        logic [3:0]  exp_valid;
        logic        exp_bad;
    } vec_t;

    typedef struct {
        int         k;
        logic [3:0] dig;
        logic       vld;
    } exp_t;

    vec_t vecs[12];
    exp_t sb[$];
    int   ntests = 0;
    int   nfail  = 0;
    int   tick_no = 0;
    int   upd_tick = -1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // One cycle: wait for the falling edge, then score any Update pulse.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        tick_no++;
        if (bus.Update === 1'b1) begin
            if (upd_tick < 0) upd_tick = tick_no;
            if (sb.size() == 0) begin
                ntests++;
                nfail++;
                $display("FAIL unexpected_update actual=1 expected=0 at tick %0d", tick_no);
            end else begin
                e = sb.pop_front();
                chk("commit_digit", 32'(bus.Digits[4*e.k +: 4]), 32'(e.dig));
                chk("commit_valid", 32'(bus.Valid[e.k]), 32'(e.vld));
            end
        end
    endtask

    initial begin
        vecs[0]  = '{4'hE, 7'h24, 1'b0, 10, 1'b1, 0, 4'h2, 1'b1, 16'hFFF2, 4'h1, 1'b0};
        vecs[1]  = '{4'hE, 7'h79, 1'b0,  8, 1'b1, 0, 4'h1, 1'b1, 16'hFFF1, 4'h1, 1'b0};
        vecs[2]  = '{4'hD, 7'h30, 1'b0,  8, 1'b1, 1, 4'h3, 1'b1, 16'hFF31, 4'h3, 1'b0};
        vecs[3]  = '{4'hB, 7'h19, 1'b0,  8, 1'b1, 2, 4'h4, 1'b1, 16'hF431, 4'h7, 1'b0};
        vecs[4]  = '{4'h7, 7'h10, 1'b0,  8, 1'b1, 3, 4'h9, 1'b1, 16'h9431, 4'hF, 1'b0};
        vecs[5]  = '{4'hE, 7'h7F, 1'b0, 10, 1'b1, 0, 4'hF, 1'b0, 16'h943F, 4'hE, 1'b0};
        vecs[6]  = '{4'hE, 7'h55, 1'b0, 10, 1'b1, 0, 4'hE, 1'b0, 16'h943E, 4'hE, 1'b1};
        vecs[7]  = '{4'hE, 7'h55, 1'b1,  4, 1'b0, 0, 4'h0, 1'b0, 16'h943E, 4'hE, 1'b0};
        vecs[8]  = '{4'hC, 7'h24, 1'b0, 20, 1'b0, 0, 4'h0, 1'b0, 16'h943E, 4'hE, 1'b0};
        vecs[9]  = '{4'hE, 7'h40, 1'b0,  3, 1'b0, 0, 4'h0, 1'b0, 16'h943E, 4'hE, 1'b0};
        vecs[10] = '{4'hE, 7'h02, 1'b0,  3, 1'b0, 0, 4'h0, 1'b0, 16'h943E, 4'hE, 1'b0};
        vecs[11] = '{4'hE, 7'h40, 1'b0, 10, 1'b1, 0, 4'h0, 1'b1, 16'h9430, 4'hF, 1'b0};

        bus.An = 4'hF;
        bus.SSeg = 7'h7F;
        bus.ClrErr = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_digits", 32'(bus.Digits), 32'hFFFF);
        chk("reset_valid",  32'(bus.Valid), 32'h0);
        chk("reset_update", 32'(bus.Update), 32'h0);
        chk("reset_badseg", 32'(bus.BadSeg), 32'h0);
        rst_n = 1'b1;
        tick();

        foreach (vecs[i]) begin
            bus.An = vecs[i].an;
            bus.SSeg = vecs[i].seg;
            bus.ClrErr = vecs[i].clr;
            if (vecs[i].commit) sb.push_back('{vecs[i].k, vecs[i].dig, vecs[i].vld});
            for (int c = 0; c < vecs[i].cycles; c++) begin
                tick();
                bus.ClrErr = 1'b0;
            end
            chk($sformatf("v%0d_pending", i), 32'(sb.size()), 32'h0);
            chk($sformatf("v%0d_digits", i), 32'(bus.Digits), 32'(vecs[i].exp_digits));
            chk($sformatf("v%0d_valid", i), 32'(bus.Valid), 32'(vecs[i].exp_valid));
            chk($sformatf("v%0d_badseg", i), 32'(bus.BadSeg), 32'(vecs[i].exp_bad));
            sb.delete();
        end

        // Asynchronous reset in the middle of a run, checked before the next rising edge.
        bus.An = 4'hD;
        bus.SSeg = 7'h02;
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("async_digits", 32'(bus.Digits), 32'hFFFF);
        chk("async_valid",  32'(bus.Valid), 32'h0);
        chk("async_update", 32'(bus.Update), 32'h0);
        chk("async_badseg", 32'(bus.BadSeg), 32'h0);
        bus.An = 4'hB;
        bus.SSeg = 7'h12;
        @(negedge clk);
        rst_n = 1'b1;
        sb.push_back('{2, 4'h5, 1'b1});
        tick_no = 0;
        upd_tick = -1;
        for (int c = 0; c < 20 && upd_tick < 0; c++) tick();
        chk("post_reset_latency", 32'(upd_tick), 32'd6);
        chk("post_reset_digits", 32'(bus.Digits), 32'hF5FF);
        chk("post_reset_valid",  32'(bus.Valid), 32'h4);
        repeat (6) tick();
        chk("post_reset_pending", 32'(sb.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
